// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and magnitude helper for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Expects a sign-extended operand; the most-negative value yields its unsigned magnitude.
  function automatic logic [63:0] mag64(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one iteration of shift-add multiply or restoring divide
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: lo holds the multiplier LSB-first; divide: lo holds the dividend MSB-first
  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, m_in} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = shifted - {1'b0, m_in};
    if (is_div) begin
      if (shifted >= {1'b0, m_in}) begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = shifted[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             done_q, done_d, busy_q;

  logic [WIDTH-1:0]   step_hi, step_lo, mag_a, mag_b, src_a, src_b;
  logic               signed_op, sign_a, sign_b;
  logic [2*WIDTH-1:0] prod;

  assign signed_op = (op == MULT) || (op == DIV);
  assign sign_a    = signed_op & a[WIDTH-1];
  assign sign_b    = signed_op & b[WIDTH-1];
  assign mag_a     = WIDTH'(mag64(64'($signed(a))));
  assign mag_b     = WIDTH'(mag64(64'($signed(b))));
  assign src_a     = signed_op ? mag_a : a;
  assign src_b     = signed_op ? mag_b : b;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .hi_in  (wh_q),
    .lo_in  (wl_q),
    .m_in   (m_q),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    prod     = neg_lo_q ? -{wh_q, wl_q} : {wh_q, wl_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_t'(op))
            MULT, MULTU: begin
              state_d  = RUN;
              cnt_d    = CW'(WIDTH - 1);
              is_div_d = 1'b0;
              wh_d     = '0;
              wl_d     = src_b;
              m_d      = src_a;
              neg_lo_d = sign_a ^ sign_b;
              neg_hi_d = 1'b0;
            end
            DIV, DIVU: begin
              state_d  = RUN;
              cnt_d    = CW'(WIDTH - 1);
              is_div_d = 1'b1;
              wh_d     = '0;
              wl_d     = src_a;
              m_d      = src_b;
              // Divide by zero: quotient stays all ones, remainder re-signs back to a
              neg_lo_d = (sign_a ^ sign_b) & (b != '0);
              neg_hi_d = sign_a;
            end
            MTHI: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            MTLO: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      RUN: begin
        wh_d = step_hi;
        wl_d = step_lo;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -wl_q : wl_q;
          hi_d = neg_hi_q ? -wh_q : wh_q;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wh_q     <= '0;
      wl_q     <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wh_q     <= wh_d;
      wl_q     <= wl_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit at WIDTH 32 and 8
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  mult_div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );
  mult_div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_hi [2];
  logic [63:0] exp_lo [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // Architectural model: signed/unsigned arithmetic on plain integers
  task automatic model(input int s, input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, pu;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    if (a[w-1]) sa = sa - (longint'(1) << w);
    sb = longint'(b);
    if (b[w-1]) sb = sb - (longint'(1) << w);
    case (op)
      MULT:  begin pu = sa * sb; exp_hi[s] = (pu >> w) & mask; exp_lo[s] = pu & mask; end
      MULTU: begin pu = a * b;   exp_hi[s] = (pu >> w) & mask; exp_lo[s] = pu & mask; end
      DIV, DIVU: begin
        if (b == 0) begin
          exp_hi[s] = a;
          exp_lo[s] = mask;
        end else if (op == DIV) begin
          q = sa / sb; r = sa % sb;
          exp_lo[s] = q & mask; exp_hi[s] = r & mask;
        end else begin
          exp_lo[s] = a / b; exp_hi[s] = a % b;
        end
      end
      MTHI: exp_hi[s] = a;
      MTLO: exp_lo[s] = a;
      default: ;
    endcase
  endtask

  task automatic drive(input int s, input logic st, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (s == 0) begin
      start32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic logic get_done(input int s);
    return (s == 0) ? done32 : done8;
  endfunction
  function automatic logic get_busy(input int s);
    return (s == 0) ? busy32 : busy8;
  endfunction
  function automatic logic [63:0] get_hi(input int s);
    return (s == 0) ? 64'(hi32) : 64'(hi8);
  endfunction
  function automatic logic [63:0] get_lo(input int s);
    return (s == 0) ? 64'(lo32) : 64'(lo8);
  endfunction

  // Issues one op; inject >= 0 pulses a MULTU 2*3 start that many edges after accept
  task automatic run(input string tag, input int s, input logic [2:0] op,
                     input logic [63:0] a, input logic [63:0] b, input int inject);
    int  w, lat;
    bit  iter, busy_ok;
    w    = (s == 0) ? 32 : 8;
    iter = (op <= 3'd3);
    @(negedge clk);
    drive(s, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(s, 1'b0, op, ~a, ~b);
    model(s, w, op, a, b);
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (get_done(s)) break;
      if (!get_busy(s)) busy_ok = 1'b0;
      if (lat == inject)          drive(s, 1'b1, MULTU, 64'd2, 64'd3);
      else if (lat == inject + 1) drive(s, 1'b0, MULTU, 64'd2, 64'd3);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%s edges", tag), 64'(lat + 1), iter ? 64'(w + 2) : 64'd1);
    check($sformatf("%s busy_run", tag), 64'(busy_ok), 64'd1);
    check($sformatf("%s busy_done", tag), 64'(get_busy(s)), 64'd0);
    check($sformatf("%s hi", tag), get_hi(s), exp_hi[s]);
    check($sformatf("%s lo", tag), get_lo(s), exp_lo[s]);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    drive(0, 1'b0, 3'd0, 64'd0, 64'd0);
    drive(1, 1'b0, 3'd0, 64'd0, 64'd0);
    for (int s = 0; s < 2; s++) begin exp_hi[s] = '0; exp_lo[s] = '0; end
    #12;
    check("reset hi", 64'(hi32), 64'd0);
    check("reset lo", 64'(lo32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    check("reset done", 64'(done32), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run("multu_max", 0, MULTU, 64'hFFFFFFFF, 64'hFFFFFFFF, -10);
    check("multu_max hi const", 64'(hi32), 64'hFFFFFFFE);
    check("multu_max lo const", 64'(lo32), 64'h00000001);
    run("mult_neg", 0, MULT, 64'hFFFFFFFD, 64'h5, -10);
    check("mult_neg lo const", 64'(lo32), 64'hFFFFFFF1);
    run("div_neg", 0, DIV, 64'hFFFFFFF9, 64'h2, -10);
    check("div_neg lo const", 64'(lo32), 64'hFFFFFFFD);
    run("divu_zero", 0, DIVU, 64'h1234, 64'h0, -10);
    check("divu_zero lo const", 64'(lo32), 64'hFFFFFFFF);
    run("div_zero_neg", 0, DIV, 64'hFFFFFF00, 64'h0, -10);
    run("div_ovf", 0, DIV, 64'h80000000, 64'hFFFFFFFF, -10);
    check("div_ovf lo const", 64'(lo32), 64'h80000000);
    run("mthi", 0, MTHI, 64'hCAFEF00D, 64'h0, -10);
    run("mtlo", 0, MTLO, 64'h12345678, 64'h0, -10);
    check("mthi hi const", 64'(hi32), 64'hCAFEF00D);
    run("invalid", 0, 3'd7, 64'h1111, 64'h2222, -10);
    run("divu_inject", 0, DIVU, 64'd100, 64'd7, 10);
    check("divu_inject lo const", 64'(lo32), 64'h0000000E);
    @(posedge clk); #1;
    check("done pulse width", 64'(done32), 64'd0);
    check("hi held after done", 64'(hi32), exp_hi[0]);

    // Abort a MULT in RUN and confirm nothing completes afterwards
    @(negedge clk); drive(0, 1'b1, MULT, 64'h1234, 64'h5678);
    @(posedge clk); #1; drive(0, 1'b0, MULT, 64'h0, 64'h0);
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    for (int s = 0; s < 2; s++) begin exp_hi[s] = '0; exp_lo[s] = '0; end
    check("abort hi", 64'(hi32), 64'd0);
    check("abort lo", 64'(lo32), 64'd0);
    check("abort busy", 64'(busy32), 64'd0);
    check("abort done", 64'(done32), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done32) seen = 1'b1; end
    check("abort late done", 64'(seen), 64'd0);

    run("w8_mult_min", 1, MULT, 64'h80, 64'h80, -10);
    check("w8_mult_min prod", {get_hi(1)[7:0], get_lo(1)[7:0]}, 64'h4000);
    run("w8_div_ovf", 1, DIV, 64'h80, 64'hFF, -10);

    for (int k = 0; k < 30; k++) begin
      int s, w;
      logic [63:0] mask, ra, rb;
      logic [2:0] rop;
      s    = int'($urandom_range(0, 1));
      w    = (s == 0) ? 32 : 8;
      mask = (64'd1 << w) - 64'd1;
      rop  = 3'($urandom_range(0, 7));
      ra   = 64'($urandom) & mask;
      rb   = 64'($urandom) & mask;
      if ($urandom_range(0, 5) == 0) rb = 64'd0;
      if ($urandom_range(0, 7) == 0) begin ra = 64'd1 << (w - 1); rb = mask; end
      run($sformatf("rand%0d op%0d w%0d", k, rop, w), s, rop, ra, rb, -10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
